// File: rtl/legup_cache_arb_pkg.sv
// rtl/legup_cache_arb_pkg.sv - shared state type, widths and round-robin helper for the cache arbiter
package legup_cache_arb_pkg;

   typedef enum logic [1:0] {
      ARB       = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DATA = 2'd2
   } arb_state_t;

   localparam int ADDR_WIDTH  = 31;
   localparam int MAX_MASTERS = 8;
   localparam int IDX_W       = 3;

   // Returns {valid, index}: first set bit of req strictly after last, wrapping modulo n.
   function automatic logic [IDX_W:0] rr_next(input logic [MAX_MASTERS-1:0] req,
                                              input logic [IDX_W-1:0]       last,
                                              input int                     n);
      logic [IDX_W:0] res;
      int             j;
      res = '0;
      for (int k = 1; k <= MAX_MASTERS; k++) begin
         j = (int'(last) + k) % n;
         if (k <= n && !res[IDX_W] && req[j[IDX_W-1:0]]) begin
            res = {1'b1, j[IDX_W-1:0]};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/legup_cache_arbiter_rr.sv
// rtl/legup_cache_arbiter_rr.sv - combinational round-robin winner selection
module legup_rr_arbiter
   import legup_cache_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 2
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [IDX_W-1:0]       last_i,
   output logic [IDX_W-1:0]       winner_o,
   output logic                   valid_o
);

   logic [MAX_MASTERS-1:0] req_ext;

   assign req_ext              = MAX_MASTERS'(req_i);
   assign {valid_o, winner_o}  = rr_next(req_ext, last_i, NUM_MASTERS);

endmodule

// File: rtl/legup_cache_arbiter.sv
// rtl/legup_cache_arbiter.sv - round-robin sharing of one cache slave port, one transaction in flight
module legup_cache_arbiter #(
   parameter int  NUM_MASTERS = 2,
   parameter int  DATA_WIDTH  = 32,
   parameter int  ADDR_WIDTH  = legup_cache_arb_pkg::ADDR_WIDTH,
   localparam int BW          = DATA_WIDTH / 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
   input  logic [NUM_MASTERS*BW-1:0]         m_byteenable,
   input  logic [NUM_MASTERS-1:0]            m_read,
   input  logic [NUM_MASTERS-1:0]            m_write,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_writedata,
   output logic [NUM_MASTERS-1:0]            m_waitrequest,
   output logic [DATA_WIDTH-1:0]             m_readdata,
   output logic [NUM_MASTERS-1:0]            m_readdatavalid,
   output logic [ADDR_WIDTH-1:0]             c_address,
   output logic [BW-1:0]                     c_byteenable,
   output logic [DATA_WIDTH-1:0]             c_writedata,
   output logic                              c_read,
   output logic                              c_write,
   input  logic [DATA_WIDTH-1:0]             c_readdata,
   input  logic                              c_readdatavalid,
   input  logic                              c_waitrequest,
   output logic                              spurious_rdv
);
   import legup_cache_arb_pkg::*;

   arb_state_t             state_q;
   logic [IDX_W-1:0]       grant_q;
   logic [IDX_W-1:0]       last_grant_q;
   logic                   grant_is_read_q;
   logic                   spurious_q;
   logic [NUM_MASTERS-1:0] req;
   logic [IDX_W-1:0]       arb_winner;
   logic                   arb_valid;
   logic                   win_read;
   logic                   win_write;

   assign req = m_read | m_write;

   legup_rr_arbiter #(
      .NUM_MASTERS(NUM_MASTERS)
   ) u_rr (
      .req_i   (req),
      .last_i  (last_grant_q),
      .winner_o(arb_winner),
      .valid_o (arb_valid)
   );

   // Command fields follow the granted master live; strobes come from the registered grant
   // so a master that drops its request mid-handshake cannot abort the cache access.
   always_comb begin
      win_read        = 1'b0;
      win_write       = 1'b0;
      c_address       = '0;
      c_byteenable    = '0;
      c_writedata     = '0;
      m_waitrequest   = '1;
      m_readdatavalid = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (arb_winner == IDX_W'(i)) begin
            win_read  = m_read[i];
            win_write = m_write[i];
         end
         if (grant_q == IDX_W'(i)) begin
            c_address    = m_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            c_byteenable = m_byteenable[i*BW +: BW];
            c_writedata  = m_writedata[i*DATA_WIDTH +: DATA_WIDTH];
            if (state_q == ISSUE) m_waitrequest[i] = c_waitrequest;
            if (state_q == WAIT_DATA) m_readdatavalid[i] = c_readdatavalid;
         end
      end
   end

   assign c_read       = (state_q == ISSUE) && grant_is_read_q;
   assign c_write      = (state_q == ISSUE) && !grant_is_read_q;
   assign m_readdata   = c_readdata;
   assign spurious_rdv = spurious_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ARB;
         grant_q         <= '0;
         last_grant_q    <= IDX_W'(NUM_MASTERS - 1);
         grant_is_read_q <= 1'b0;
         spurious_q      <= 1'b0;
      end else begin
         case (state_q)
            ARB: begin
               if (arb_valid) begin
                  grant_q         <= arb_winner;
                  grant_is_read_q <= win_read && !win_write;
                  state_q         <= ISSUE;
               end
            end
            ISSUE: begin
               if (!c_waitrequest) begin
                  last_grant_q <= grant_q;
                  state_q      <= grant_is_read_q ? WAIT_DATA : ARB;
               end
            end
            WAIT_DATA: begin
               if (c_readdatavalid) state_q <= ARB;
            end
            default: state_q <= ARB;
         endcase
         if (c_readdatavalid && state_q != WAIT_DATA) spurious_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_legup_cache_arbiter.sv
// tb/tb_legup_cache_arbiter.sv - self-checking bench for legup_cache_arbiter
module tb_legup_cache_arbiter;

   localparam int NM = 3;
   localparam int DW = 32;
   localparam int AW = 31;
   localparam int BW = DW / 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [NM*AW-1:0] m_address;
   logic [NM*BW-1:0] m_byteenable;
   logic [NM-1:0]    m_read;
   logic [NM-1:0]    m_write;
   logic [NM*DW-1:0] m_writedata;
   logic [NM-1:0]    m_waitrequest;
   logic [DW-1:0]    m_readdata;
   logic [NM-1:0]    m_readdatavalid;
   logic [AW-1:0]    c_address;
   logic [BW-1:0]    c_byteenable;
   logic [DW-1:0]    c_writedata;
   logic             c_read;
   logic             c_write;
   logic [DW-1:0]    c_readdata;
   logic             c_readdatavalid;
   logic             c_waitrequest;
   logic             spurious_rdv;

   logic [AW-1:0] ma [NM];
   logic [BW-1:0] mb [NM];
   logic [DW-1:0] md [NM];
   logic [NM-1:0] mr;
   logic [NM-1:0] mw;

   int checks = 0;
   int errors = 0;

   legup_cache_arbiter #(
      .NUM_MASTERS(NM),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .m_address      (m_address),
      .m_byteenable   (m_byteenable),
      .m_read         (m_read),
      .m_write        (m_write),
      .m_writedata    (m_writedata),
      .m_waitrequest  (m_waitrequest),
      .m_readdata     (m_readdata),
      .m_readdatavalid(m_readdatavalid),
      .c_address      (c_address),
      .c_byteenable   (c_byteenable),
      .c_writedata    (c_writedata),
      .c_read         (c_read),
      .c_write        (c_write),
      .c_readdata     (c_readdata),
      .c_readdatavalid(c_readdatavalid),
      .c_waitrequest  (c_waitrequest),
      .spurious_rdv   (spurious_rdv)
   );

   always #5 clk = ~clk;

   task automatic pack();
      for (int i = 0; i < NM; i++) begin
         m_address[i*AW +: AW]    = ma[i];
         m_byteenable[i*BW +: BW] = mb[i];
         m_writedata[i*DW +: DW]  = md[i];
      end
      m_read  = mr;
      m_write = mw;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      mr = '0;
      mw = '0;
      for (int i = 0; i < NM; i++) begin
         ma[i] = AW'($urandom);
         mb[i] = BW'($urandom);
         md[i] = $urandom;
      end
      pack();
      c_readdatavalid = 1'b0;
      c_waitrequest   = 1'b0;
      c_readdata      = '0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      c_readdatavalid = 1'b0;
      c_waitrequest   = 1'b0;
      c_readdata      = '0;
      for (int i = 0; i < NM; i++) begin
         ma[i] = AW'($urandom);
         mb[i] = BW'($urandom);
         md[i] = $urandom;
      end
      mr = '1;
      mw = '0;
      pack();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (m_waitrequest !== {NM{1'b1}}) begin errors++; $display("FAIL rst_waitreq: got %b want %b", m_waitrequest, {NM{1'b1}}); end
      checks++; if (m_readdatavalid !== '0) begin errors++; $display("FAIL rst_rdv: got %b want 0", m_readdatavalid); end
      checks++; if (c_read !== 1'b0 || c_write !== 1'b0) begin errors++; $display("FAIL rst_cmd: got rd=%b wr=%b want 0 0", c_read, c_write); end
      checks++; if (spurious_rdv !== 1'b0) begin errors++; $display("FAIL rst_spurious: got %b want 0", spurious_rdv); end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++; if (c_read !== 1'b0) begin errors++; $display("FAIL rst_arb_idle: got c_read=%b want 0", c_read); end
      tick();
      @(negedge clk);
      checks++; if (c_read !== 1'b1 || c_address !== ma[0]) begin errors++; $display("FAIL rst_first_grant: got rd=%b addr=%h want 1 %h", c_read, c_address, ma[0]); end
      checks++; if (m_waitrequest !== 3'b110) begin errors++; $display("FAIL rst_first_wait: got %b want 110", m_waitrequest); end
      tick();
      mr = '0;
      pack();
   endtask

   task automatic test_single_write();
      do_reset();
      ma[1] = 31'h100;
      md[1] = 32'hDEADBEEF;
      mb[1] = 4'hF;
      mw    = 3'b010;
      pack();
      @(negedge clk);
      checks++; if (c_write !== 1'b0) begin errors++; $display("FAIL sw_latency: got c_write=%b want 0", c_write); end
      tick();
      @(negedge clk);
      checks++; if (c_write !== 1'b1 || c_read !== 1'b0) begin errors++; $display("FAIL sw_strobe: got wr=%b rd=%b want 1 0", c_write, c_read); end
      checks++; if (c_address !== 31'h100) begin errors++; $display("FAIL sw_addr: got %h want 100", c_address); end
      checks++; if (c_writedata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_data: got %h want deadbeef", c_writedata); end
      checks++; if (c_byteenable !== 4'hF) begin errors++; $display("FAIL sw_be: got %h want f", c_byteenable); end
      checks++; if (m_waitrequest !== 3'b101) begin errors++; $display("FAIL sw_wait: got %b want 101", m_waitrequest); end
      tick();
      mw = '0;
      pack();
      @(negedge clk);
      checks++; if (c_write !== 1'b0 || m_waitrequest !== 3'b111) begin errors++; $display("FAIL sw_done: got wr=%b wait=%b want 0 111", c_write, m_waitrequest); end
   endtask

   task automatic test_contention();
      int            exp;
      logic [DW-1:0] data;
      logic [NM-1:0] ew;
      logic [NM-1:0] er;
      do_reset();
      ma[0] = 31'h10;
      ma[1] = 31'h20;
      mr    = 3'b011;
      pack();
      for (int t = 0; t < 6; t++) begin
         exp     = t % 2;
         ew      = '1;
         ew[exp] = 1'b0;
         er      = '0;
         er[exp] = 1'b1;
         @(negedge clk);
         checks++; if (c_read !== 1'b0) begin errors++; $display("FAIL ct_arb_idle: txn %0d got c_read=%b want 0", t, c_read); end
         tick();
         @(negedge clk);
         checks++; if (c_read !== 1'b1 || c_address !== ma[exp]) begin errors++; $display("FAIL ct_grant: txn %0d got rd=%b addr=%h want 1 %h", t, c_read, c_address, ma[exp]); end
         checks++; if (m_waitrequest !== ew) begin errors++; $display("FAIL ct_wait: txn %0d got %b want %b", t, m_waitrequest, ew); end
         tick();
         data            = $urandom;
         c_readdata      = data;
         c_readdatavalid = 1'b1;
         @(negedge clk);
         checks++; if (m_readdatavalid !== er) begin errors++; $display("FAIL ct_rdv: txn %0d got %b want %b", t, m_readdatavalid, er); end
         checks++; if (m_readdata !== data) begin errors++; $display("FAIL ct_rdata: txn %0d got %h want %h", t, m_readdata, data); end
         tick();
         c_readdatavalid = 1'b0;
      end
      mr = '0;
      pack();
   endtask

   task automatic test_read_miss();
      logic [DW-1:0] data;
      do_reset();
      ma[1] = 31'h200;
      mr    = 3'b010;
      pack();
      tick();
      tick();
      ma[0] = 31'h300;
      mr    = 3'b001;
      pack();
      data = $urandom;
      for (int w = 1; w <= 10; w++) begin
         if (w == 10) begin
            c_readdata      = data;
            c_readdatavalid = 1'b1;
         end
         @(negedge clk);
         checks++; if (m_waitrequest[0] !== 1'b1) begin errors++; $display("FAIL rm_stall: wait cycle %0d got %b want 1", w, m_waitrequest[0]); end
         checks++; if (m_readdatavalid !== ((w == 10) ? 3'b010 : 3'b000)) begin errors++; $display("FAIL rm_rdv: wait cycle %0d got %b", w, m_readdatavalid); end
         if (w == 10) begin
            checks++; if (m_readdata !== data) begin errors++; $display("FAIL rm_rdata: got %h want %h", m_readdata, data); end
         end
         tick();
         c_readdatavalid = 1'b0;
      end
      @(negedge clk);
      checks++; if (m_waitrequest !== 3'b111) begin errors++; $display("FAIL rm_after_return: got %b want 111", m_waitrequest); end
      tick();
      @(negedge clk);
      checks++; if (m_waitrequest !== 3'b110 || c_read !== 1'b1 || c_address !== 31'h300) begin errors++; $display("FAIL rm_next_grant: got wait=%b rd=%b addr=%h want 110 1 300", m_waitrequest, c_read, c_address); end
      tick();
      mr = '0;
      pack();
   endtask

   task automatic test_cache_stall();
      do_reset();
      mw = 3'b001;
      pack();
      tick();
      tick();
      ma[2] = 31'h44;
      md[2] = $urandom;
      mb[2] = 4'h3;
      mw    = 3'b100;
      pack();
      c_waitrequest = 1'b1;
      tick();
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         checks++; if (c_write !== 1'b1 || c_address !== ma[2] || c_writedata !== md[2] || c_byteenable !== mb[2]) begin
            errors++; $display("FAIL cs_stable: stall %0d got wr=%b addr=%h data=%h be=%h", s, c_write, c_address, c_writedata, c_byteenable);
         end
         checks++; if (m_waitrequest !== 3'b111) begin errors++; $display("FAIL cs_wait: stall %0d got %b want 111", s, m_waitrequest); end
         tick();
         if (s == 2) begin
            mr = 3'b011;
            pack();
         end
      end
      c_waitrequest = 1'b0;
      @(negedge clk);
      checks++; if (m_waitrequest !== 3'b011) begin errors++; $display("FAIL cs_accept: got %b want 011", m_waitrequest); end
      tick();
      mw = '0;
      pack();
      @(negedge clk);
      checks++; if (c_read !== 1'b0 || c_write !== 1'b0) begin errors++; $display("FAIL cs_arb: got rd=%b wr=%b want 0 0", c_read, c_write); end
      tick();
      @(negedge clk);
      checks++; if (c_read !== 1'b1 || c_address !== ma[0] || m_waitrequest !== 3'b110) begin errors++; $display("FAIL cs_last_grant: got rd=%b addr=%h wait=%b want 1 %h 110", c_read, c_address, m_waitrequest, ma[0]); end
      tick();
      mr = '0;
      pack();
   endtask

   task automatic test_async_reset();
      do_reset();
      mr = 3'b010;
      pack();
      tick();
      tick();
      mr = '0;
      pack();
      @(negedge clk);
      #1;
      reset           = 1'b1;
      c_readdatavalid = 1'b1;
      #1;
      checks++; if (m_readdatavalid !== '0) begin errors++; $display("FAIL ar_rdv: got %b want 0", m_readdatavalid); end
      checks++; if (m_waitrequest !== 3'b111) begin errors++; $display("FAIL ar_wait: got %b want 111", m_waitrequest); end
      checks++; if (c_read !== 1'b0 || c_write !== 1'b0) begin errors++; $display("FAIL ar_cmd: got rd=%b wr=%b want 0 0", c_read, c_write); end
      checks++; if (spurious_rdv !== 1'b0) begin errors++; $display("FAIL ar_spurious: got %b want 0", spurious_rdv); end
      c_readdatavalid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      mr = 3'b011;
      pack();
      @(negedge clk);
      checks++; if (c_read !== 1'b0) begin errors++; $display("FAIL ar_arb: got c_read=%b want 0", c_read); end
      tick();
      @(negedge clk);
      checks++; if (c_read !== 1'b1 || c_address !== ma[0] || m_waitrequest !== 3'b110) begin errors++; $display("FAIL ar_first: got rd=%b addr=%h wait=%b want 1 %h 110", c_read, c_address, m_waitrequest, ma[0]); end
      tick();
      mr = '0;
      pack();
   endtask

   task automatic test_spurious();
      do_reset();
      c_readdata      = $urandom;
      c_readdatavalid = 1'b1;
      @(negedge clk);
      checks++; if (m_readdatavalid !== '0) begin errors++; $display("FAIL sp_rdv: got %b want 0", m_readdatavalid); end
      tick();
      c_readdatavalid = 1'b0;
      @(negedge clk);
      checks++; if (spurious_rdv !== 1'b1) begin errors++; $display("FAIL sp_flag: got %b want 1", spurious_rdv); end
      repeat (3) tick();
      @(negedge clk);
      checks++; if (spurious_rdv !== 1'b1) begin errors++; $display("FAIL sp_sticky: got %b want 1", spurious_rdv); end
      tick();
   endtask

   // Transaction-level model: bus free -> pick RR winner among requesters; issue until the
   // cache accepts; reads then wait for the return strobe, which goes to the issuing master.
   task automatic test_random_traffic();
      int            last_served, owner, rd_delay, j, kind;
      bit            free, issuing, awaiting, exp_wr, rdv_now, found;
      logic [DW-1:0] rd_data;
      logic [NM-1:0] ew, er;
      do_reset();
      last_served = NM - 1;
      free = 1; issuing = 0; awaiting = 0; owner = 0; rd_delay = 0; exp_wr = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int i = 0; i < NM; i++) begin
            if (!(mr[i] || mw[i]) && $urandom_range(0, 2) == 0) begin
               kind  = $urandom_range(0, 4);
               mr[i] = (kind < 2) || (kind == 4);
               mw[i] = (kind >= 2);
               ma[i] = AW'($urandom);
               md[i] = $urandom;
               mb[i] = BW'($urandom);
            end
         end
         pack();
         c_waitrequest   = ($urandom_range(0, 2) == 0);
         rdv_now         = awaiting && (rd_delay == 0);
         if (awaiting && rd_delay > 0) rd_delay--;
         rd_data         = $urandom;
         c_readdata      = rd_data;
         c_readdatavalid = rdv_now;
         @(negedge clk);
         ew = '1;
         er = '0;
         if (issuing) ew[owner] = c_waitrequest;
         if (rdv_now) er[owner] = 1'b1;
         checks++; if (m_waitrequest !== ew) begin errors++; $display("FAIL rnd_wait: cycle %0d got %b want %b", cyc, m_waitrequest, ew); end
         checks++; if (m_readdatavalid !== er) begin errors++; $display("FAIL rnd_rdv: cycle %0d got %b want %b", cyc, m_readdatavalid, er); end
         if (issuing) begin
            checks++; if (c_write !== exp_wr || c_read !== !exp_wr) begin errors++; $display("FAIL rnd_strobe: cycle %0d got rd=%b wr=%b want wr=%b", cyc, c_read, c_write, exp_wr); end
            checks++; if (c_address !== ma[owner] || c_byteenable !== mb[owner] || c_writedata !== md[owner]) begin
               errors++; $display("FAIL rnd_fields: cycle %0d master %0d got addr=%h be=%h data=%h want %h %h %h", cyc, owner, c_address, c_byteenable, c_writedata, ma[owner], mb[owner], md[owner]);
            end
         end else begin
            checks++; if (c_read !== 1'b0 || c_write !== 1'b0) begin errors++; $display("FAIL rnd_idle: cycle %0d got rd=%b wr=%b want 0 0", cyc, c_read, c_write); end
         end
         if (rdv_now) begin
            checks++; if (m_readdata !== rd_data) begin errors++; $display("FAIL rnd_rdata: cycle %0d got %h want %h", cyc, m_readdata, rd_data); end
         end
         if (free) begin
            found = 0;
            for (int k = 1; k <= NM; k++) begin
               j = (last_served + k) % NM;
               if (!found && (mr[j] || mw[j])) begin
                  owner = j;
                  found = 1;
               end
            end
            if (found) begin
               exp_wr  = mw[owner];
               free    = 0;
               issuing = 1;
            end
         end else if (issuing) begin
            if (!c_waitrequest) begin
               mr[owner]   = 1'b0;
               mw[owner]   = 1'b0;
               last_served = owner;
               issuing     = 0;
               if (exp_wr) begin
                  free = 1;
               end else begin
                  awaiting = 1;
                  rd_delay = $urandom_range(0, 4);
               end
            end
         end else if (awaiting && rdv_now) begin
            awaiting = 0;
            free     = 1;
         end
         tick();
      end
      checks++; if (spurious_rdv !== 1'b0) begin errors++; $display("FAIL rnd_spurious: got %b want 0", spurious_rdv); end
      mr = '0;
      mw = '0;
      pack();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got still running want finished");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_write();
      test_contention();
      test_read_miss();
      test_cache_stall();
      test_async_reset();
      test_spurious();
      test_random_traffic();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
